// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// bit_serializer_pkg: FSM encoding shared by the serializer and by benches
// that chain it into the 1010 detector.  Rev 1.0
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] DET_PATTERN = 4'b1010;

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// bit_serializer: valid/ready parallel word in, one bit per enabled clock out,
// back-to-back words with no gap bit.  Rev 1.0
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             enable,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             last_bit;

  assign last_bit   = (cnt_q == CNT_LAST);
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    x_out        = IDLE_BIT;
    x_valid      = 1'b0;
    busy         = 1'b0;
    din_ready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // enable is deliberately ignored here so a word can be taken while stalled
        din_ready = 1'b1;
        if (din_valid) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        x_valid   = 1'b1;
        busy      = 1'b1;
        x_out     = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
        din_ready = last_bit && enable;
        if (enable) begin
          if (!last_bit) begin
            if (MSB_FIRST != 0) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            else                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
          end else begin
            frame_done_d = 1'b1;
            // Reload on the last bit keeps the bit stream contiguous across words
            if (din_valid) begin
              shreg_d = din;
              cnt_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// tb_bit_serializer: directed checks of the serializer, including a small
// 1010 Mealy detector model fed from the serial output.  Rev 1.0
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid, enable;
  logic       din_ready, x_out, x_valid, busy, frame_done;

  logic [7:0] l_din;
  logic       l_valid, l_enable;
  logic       l_ready, l_x_out, l_x_valid, l_busy, l_frame_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .reset(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .enable(enable), .x_out(x_out),
    .x_valid(x_valid), .busy(busy), .frame_done(frame_done)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(rst_n), .din(l_din), .din_valid(l_valid),
    .din_ready(l_ready), .enable(l_enable), .x_out(l_x_out),
    .x_valid(l_x_valid), .busy(l_busy), .frame_done(l_frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 8'hFF; din_valid = 1'b1; enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (x_valid !== 1'b0 || x_out !== 1'b0 || din_ready !== 1'b1 ||
          frame_done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset c%0d: valid=%b x=%b rdy=%b fd=%b busy=%b, want 0 0 1 0 0",
                 c, x_valid, x_out, din_ready, frame_done, busy);
      end
    end
    din_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: valid=%b busy=%b rdy=%b, want 0 0 1", x_valid, busy, din_ready);
    end
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    exp = 8'b10100101;
    din = 8'hA5; din_valid = 1'b1; enable = 1'b1;
    @(negedge clk);
    n_vec++;
    if (din_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got %b want 1", din_ready);
    end
    tick();
    din_valid = 1'b0; din = 8'h3C;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (x_out !== exp[8-c] || x_valid !== 1'b1 || frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL single_bit%0d: x=%b valid=%b fd=%b, want %b 1 0",
                 c, x_out, x_valid, frame_done, exp[8-c]);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1 || x_valid !== 1'b0) begin
      n_err++; $display("FAIL single_done: fd=%b valid=%b, want 1 0", frame_done, x_valid);
    end
    tick();
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0) begin
      n_err++; $display("FAIL single_done_width: fd=%b want 0", frame_done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'b1010101001010101;
    din = 8'hAA; din_valid = 1'b1; enable = 1'b1;
    tick();
    din = 8'h55;
    for (int c = 1; c <= 16; c++) begin
      if (c == 9) begin
        din_valid = 1'b0; din = 8'hFF;
      end
      @(negedge clk);
      n_vec++;
      if (x_out !== exp[16-c] || x_valid !== 1'b1 ||
          din_ready !== (c == 8 || c == 16) || frame_done !== (c == 9)) begin
        n_err++;
        $display("FAIL b2b_c%0d: x=%b valid=%b rdy=%b fd=%b, want %b 1 %b %b",
                 c, x_out, x_valid, din_ready, frame_done, exp[16-c],
                 (c == 8 || c == 16), (c == 9));
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1 || x_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_done: fd=%b valid=%b, want 1 0", frame_done, x_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [9:0] exp;
    exp = 10'b1011100101;
    din = 8'hA5; din_valid = 1'b1; enable = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      enable = !(c == 3 || c == 4);
      @(negedge clk);
      n_vec++;
      if (x_out !== exp[10-c] || x_valid !== 1'b1 || din_ready !== (c == 10)) begin
        n_err++;
        $display("FAIL stall_c%0d: x=%b valid=%b rdy=%b, want %b 1 %b",
                 c, x_out, x_valid, din_ready, exp[10-c], (c == 10));
      end
      tick();
    end
    enable = 1'b1;
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1 || x_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_done: fd=%b valid=%b, want 1 0", frame_done, x_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp;
    exp = 8'b00001111;
    din = 8'hA5; din_valid = 1'b1; enable = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (x_out !== 1'b0 || x_valid !== 1'b1) begin
      n_err++; $display("FAIL midrst_bit4: x=%b valid=%b, want 0 1", x_out, x_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || x_out !== 1'b0 || din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_async: valid=%b busy=%b x=%b rdy=%b, want 0 0 0 1",
               x_valid, busy, x_out, din_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    din = 8'h0F; din_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (x_valid !== 1'b0 || din_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_idle: valid=%b rdy=%b, want 0 1", x_valid, din_ready);
    end
    tick();
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (x_out !== exp[8-c] || x_valid !== 1'b1) begin
        n_err++;
        $display("FAIL midrst_bit%0d: x=%b valid=%b, want %b 1", c, x_out, x_valid, exp[8-c]);
      end
      tick();
    end
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b1) begin
      n_err++; $display("FAIL midrst_done: fd=%b want 1", frame_done);
    end
    tick();
  endtask

  task automatic test_detector_chain();
    logic [7:0] exp;
    logic [2:0] hist;
    logic       y;
    // LSB-first instance: 8'h05 -> 1,0,1,0,0,0,0,0, detector fires on bit 4
    exp = 8'b10100000;
    hist = 3'b000;
    l_din = 8'h05; l_valid = 1'b1; l_enable = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      y = l_x_valid && ({hist, l_x_out} == DET_PATTERN);
      n_vec++;
      if (l_x_out !== exp[8-c] || y !== (c == 4)) begin
        n_err++;
        $display("FAIL chain_lsb_c%0d: x=%b y=%b, want %b %b", c, l_x_out, y, exp[8-c], (c == 4));
      end
      hist = {hist[1:0], l_x_out};
      tick();
    end
    tick();
    // MSB-first instance: 8'h0A -> 0,0,0,0,1,0,1,0, detector fires on bit 8
    exp = 8'b00001010;
    hist = 3'b000;
    din = 8'h0A; din_valid = 1'b1; enable = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      y = x_valid && ({hist, x_out} == DET_PATTERN);
      n_vec++;
      if (x_out !== exp[8-c] || y !== (c == 8)) begin
        n_err++;
        $display("FAIL chain_msb_c%0d: x=%b y=%b, want %b %b", c, x_out, y, exp[8-c], (c == 8));
      end
      hist = {hist[1:0], x_out};
      tick();
    end
    repeat (2) tick();
  endtask

  initial begin
    l_din = 8'h00; l_valid = 1'b0; l_enable = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_detector_chain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
